zxuno_regbus_ctrl: RTL and testbench

- Sequences the ZX-UNO internal register bus from Z80 I/O cycles.
- Decodes the address port (0xFC3B) and data port (0xFD3B).
- Holds the selected register number and generates the read-level, write-pulse and address-changed strobes that register peripherals (core ID string, config registers) consume.
- Arbitrates the peripherals' tri-state style responses into one CPU read bus.

---
 rtl/zxuno_regbus_if.sv | 33 +++
 rtl/zxuno_regbus_ctrl.sv | 113 +++++++++++
 tb/tb_zxuno_regbus_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/zxuno_regbus_if.sv
// ZX-UNO register bus bundle: Z80 I/O side, register strobes and the
// peripheral response lines collected into one port.
interface zxuno_regbus_if #(
  parameter int NPERIPH = 4
);
  logic [15:0]          cpu_a;
  logic                 cpu_iorq_n;
  logic                 cpu_rd_n;
  logic                 cpu_wr_n;
  logic [7:0]           cpu_din;
  logic [7:0]           cpu_dout;
  logic                 cpu_oe_n;
  logic [7:0]           zxuno_addr;
  logic                 zxuno_regrd;
  logic                 zxuno_regwr;
  logic [7:0]           zxuno_wrdata;
  logic                 regaddr_changed;
  logic [8*NPERIPH-1:0] per_dout;
  logic [NPERIPH-1:0]   per_oe_n;

  // CPU plus peripherals drive the controller
  modport master (
    output cpu_a, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_din, per_dout, per_oe_n,
    input  cpu_dout, cpu_oe_n, zxuno_addr, zxuno_regrd, zxuno_regwr,
           zxuno_wrdata, regaddr_changed
  );

  modport slave (
    input  cpu_a, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_din, per_dout, per_oe_n,
    output cpu_dout, cpu_oe_n, zxuno_addr, zxuno_regrd, zxuno_regwr,
           zxuno_wrdata, regaddr_changed
  );
endinterface

// File: rtl/zxuno_regbus_ctrl.sv
// ZX-UNO register bus sequencer: decodes the address/data I/O ports, holds the
// selected register, generates regrd/regwr/addr-changed strobes, muxes read data.
module zxuno_regbus_ctrl #(
  parameter int          NPERIPH    = 4,
  parameter logic [15:0] ADDR_PORT  = 16'hFC3B,
  parameter logic [15:0] DATA_PORT  = 16'hFD3B,
  parameter logic [7:0]  RESET_ADDR = 8'h00
) (
  input logic           clk,
  input logic           rst,
  zxuno_regbus_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    AWR      = 3'd1,
    DRD      = 3'd2,
    DWR      = 3'd3,
    WAIT_END = 3'd4
  } state_t;

  state_t     state_reg, state_next;
  logic       acc_a, acc_d;
  logic [7:0] addr_reg, addr_next;
  logic [7:0] wrdata_reg, wrdata_next;
  logic       regrd_reg, regrd_next;
  logic       regwr_reg, regwr_next;
  logic       chg_reg, chg_next;
  logic       oe_n_reg, oe_n_next;
  logic       rd_addr_reg, rd_addr_next;
  logic [7:0] per_data [NPERIPH];
  logic [7:0] per_sel;

  assign acc_a = !bus.cpu_iorq_n && (bus.cpu_a == ADDR_PORT);
  assign acc_d = !bus.cpu_iorq_n && (bus.cpu_a == DATA_PORT);

  for (genvar gi = 0; gi < NPERIPH; gi++) begin : g_per_unpack
    assign per_data[gi] = bus.per_dout[8*gi +: 8];
  end

  // Lowest-indexed enabled peripheral wins; an undriven bus reads as 0xFF.
  always_comb begin
    per_sel = 8'hFF;
    for (int k = NPERIPH - 1; k >= 0; k--) begin
      if (!bus.per_oe_n[k]) per_sel = per_data[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= WAIT_END;
      addr_reg    <= RESET_ADDR;
      wrdata_reg  <= 8'h00;
      regrd_reg   <= 1'b0;
      regwr_reg   <= 1'b0;
      chg_reg     <= 1'b0;
      oe_n_reg    <= 1'b1;
      rd_addr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      wrdata_reg  <= wrdata_next;
      regrd_reg   <= regrd_next;
      regwr_reg   <= regwr_next;
      chg_reg     <= chg_next;
      oe_n_reg    <= oe_n_next;
      rd_addr_reg <= rd_addr_next;
    end
  end

  // Writes take priority over reads when both strobes are low.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (acc_a && !bus.cpu_wr_n)                 state_next = AWR;
        else if (acc_d && !bus.cpu_wr_n)            state_next = DWR;
        else if ((acc_a || acc_d) && !bus.cpu_rd_n) state_next = DRD;
      end
      AWR, DWR: state_next = WAIT_END;
      DRD: begin
        if (bus.cpu_iorq_n || bus.cpu_rd_n) state_next = IDLE;
      end
      WAIT_END: begin
        if (bus.cpu_iorq_n) state_next = IDLE;
      end
      default: state_next = WAIT_END;
    endcase
  end

  always_comb begin
    addr_next    = addr_reg;
    wrdata_next  = wrdata_reg;
    rd_addr_next = rd_addr_reg;
    if (state_reg == IDLE) rd_addr_next = acc_a;
    if (state_reg == AWR)  addr_next    = bus.cpu_din;
    if (state_reg == DWR)  wrdata_next  = bus.cpu_din;
    // Strobe pulses land in the WAIT_END cycle that always follows AWR/DWR.
    chg_next   = (state_reg == AWR);
    regwr_next = (state_reg == DWR);
    regrd_next = (state_next == DRD) && !rd_addr_next;
    oe_n_next  = (state_next != DRD);
  end

  assign bus.cpu_dout        = oe_n_reg ? 8'hFF : (rd_addr_reg ? addr_reg : per_sel);
  assign bus.cpu_oe_n        = oe_n_reg;
  assign bus.zxuno_addr      = addr_reg;
  assign bus.zxuno_regrd     = regrd_reg;
  assign bus.zxuno_regwr     = regwr_reg;
  assign bus.zxuno_wrdata    = wrdata_reg;
  assign bus.regaddr_changed = chg_reg;

endmodule

// File: tb/tb_zxuno_regbus_ctrl.sv
// Directed bench for zxuno_regbus_ctrl: drives Z80 I/O cycles and checks
// strobes, latched values and the read mux against hand-computed values.
module tb_zxuno_regbus_ctrl;

  logic clk;
  logic rst;

  zxuno_regbus_if #(.NPERIPH(4)) bus ();

  zxuno_regbus_ctrl #(.NPERIPH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // observations accumulated by step()
  int         n_chg, n_wr, n_rd_int, n_oe;
  logic [7:0] wr_data_seen, wr_addr_seen, dout_seen;
  logic       prev_rd;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clear_counts();
    n_chg = 0; n_wr = 0; n_rd_int = 0; n_oe = 0;
    wr_data_seen = 8'h00; wr_addr_seen = 8'h00; dout_seen = 8'h00;
    prev_rd = bus.zxuno_regrd;
  endtask

  task automatic step();
    @(negedge clk);
    if (bus.regaddr_changed) n_chg++;
    if (bus.zxuno_regwr) begin
      n_wr++;
      wr_data_seen = bus.zxuno_wrdata;
      wr_addr_seen = bus.zxuno_addr;
    end
    if (bus.zxuno_regrd && !prev_rd) n_rd_int++;
    prev_rd = bus.zxuno_regrd;
    if (!bus.cpu_oe_n) begin
      n_oe++;
      dout_seen = bus.cpu_dout;
    end
  endtask

  task automatic bus_idle();
    bus.cpu_iorq_n = 1'b1;
    bus.cpu_rd_n   = 1'b1;
    bus.cpu_wr_n   = 1'b1;
  endtask

  task automatic io_cycle(input logic [15:0] a, input logic is_wr, input logic [7:0] d,
                          input int ncyc, input int gap);
    $display("io %s a=0x%04h d=0x%02h cycles=%0d", is_wr ? "OUT" : "IN ", a, d, ncyc);
    bus.cpu_a      = a;
    bus.cpu_din    = d;
    bus.cpu_iorq_n = 1'b0;
    if (is_wr) bus.cpu_wr_n = 1'b0;
    else       bus.cpu_rd_n = 1'b0;
    repeat (ncyc) step();
    bus_idle();
    repeat (gap) step();
  endtask

  initial begin
    rst          = 1'b1;
    bus.cpu_a    = 16'h0000;
    bus.cpu_din  = 8'h00;
    bus.per_dout = 32'h0000_0000;
    bus.per_oe_n = 4'b1111;
    bus_idle();
    clear_counts();

    // reset state
    repeat (2) @(negedge clk);
    check("rst_addr",   bus.zxuno_addr, 8'h00);
    check("rst_wrdata", bus.zxuno_wrdata, 8'h00);
    check("rst_regrd",  bus.zxuno_regrd, 1'b0);
    check("rst_regwr",  bus.zxuno_regwr, 1'b0);
    check("rst_chg",    bus.regaddr_changed, 1'b0);
    check("rst_oe_n",   bus.cpu_oe_n, 1'b1);
    check("rst_dout",   bus.cpu_dout, 8'hFF);
    rst = 1'b0;
    repeat (2) step();

    // address-port write
    clear_counts();
    io_cycle(16'hFC3B, 1'b1, 8'hFF, 4, 4);
    check("awr_addr",  bus.zxuno_addr, 8'hFF);
    check("awr_chg_n", n_chg, 1);
    check("awr_wr_n",  n_wr, 0);
    check("awr_rd_n",  n_rd_int, 0);
    check("awr_oe_n",  n_oe, 0);

    // address-port readback
    io_cycle(16'hFC3B, 1'b1, 8'h05, 4, 4);
    clear_counts();
    io_cycle(16'hFC3B, 1'b0, 8'h00, 6, 4);
    check("ard_oe_cycles", n_oe, 6);
    check("ard_dout",      dout_seen, 8'h05);
    check("ard_regrd",     n_rd_int, 0);

    // data-port write held for many cycles
    io_cycle(16'hFC3B, 1'b1, 8'h01, 4, 4);
    clear_counts();
    io_cycle(16'hFD3B, 1'b1, 8'hA5, 10, 4);
    check("dwr_pulses", n_wr, 1);
    check("dwr_data",   wr_data_seen, 8'hA5);
    check("dwr_addr",   wr_addr_seen, 8'h01);
    check("dwr_chg",    n_chg, 0);
    check("dwr_latch",  bus.zxuno_wrdata, 8'hA5);

    // peripheral priority mux, three reads separated by a single idle cycle
    bus.per_oe_n = 4'b1001;
    bus.per_dout = {8'h99, 8'h31, 8'h54, 8'h77};
    clear_counts();
    io_cycle(16'hFD3B, 1'b0, 8'h00, 4, 1);
    io_cycle(16'hFD3B, 1'b0, 8'h00, 4, 1);
    io_cycle(16'hFD3B, 1'b0, 8'h00, 4, 4);
    check("mux_rd_intervals", n_rd_int, 3);
    check("mux_oe_cycles",    n_oe, 12);
    check("mux_dout",         dout_seen, 8'h54);

    // no peripheral driving
    bus.per_oe_n = 4'b1111;
    clear_counts();
    io_cycle(16'hFD3B, 1'b0, 8'h00, 3, 4);
    check("none_dout",  dout_seen, 8'hFF);
    check("none_oe",    n_oe, 3);
    check("none_rd",    n_rd_int, 1);

    // reset in the middle of a data-port read
    bus.per_oe_n = 4'b1110;
    $display("io IN  a=0xfd3b interrupted by reset");
    bus.cpu_a      = 16'hFD3B;
    bus.cpu_iorq_n = 1'b0;
    bus.cpu_rd_n   = 1'b0;
    step();
    step();
    check("mid_regrd_pre", bus.zxuno_regrd, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("mid_regrd_rst", bus.zxuno_regrd, 1'b0);
    check("mid_oe_rst",    bus.cpu_oe_n, 1'b1);
    check("mid_addr_rst",  bus.zxuno_addr, 8'h00);
    check("mid_dout_rst",  bus.cpu_dout, 8'hFF);
    @(negedge clk);
    rst = 1'b0;
    clear_counts();
    repeat (3) step();
    check("mid_hold_rd", n_rd_int, 0);
    check("mid_hold_oe", n_oe, 0);
    bus_idle();
    repeat (2) step();
    clear_counts();
    io_cycle(16'hFD3B, 1'b0, 8'h00, 3, 4);
    check("mid_new_rd",   n_rd_int, 1);
    check("mid_new_dout", dout_seen, 8'h77);

    // non-decoded ports
    io_cycle(16'hFC3B, 1'b1, 8'h12, 4, 4);
    clear_counts();
    io_cycle(16'hFC3C, 1'b1, 8'h77, 4, 4);
    io_cycle(16'h003B, 1'b0, 8'h00, 4, 4);
    check("nd_chg",  n_chg, 0);
    check("nd_wr",   n_wr, 0);
    check("nd_rd",   n_rd_int, 0);
    check("nd_oe",   n_oe, 0);
    check("nd_addr", bus.zxuno_addr, 8'h12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
